// File: rtl/writeback_pkg.sv
// Shared Y86 bus/status macros and writeback types (W-register entry, status FSM states).
// Optional retire counter is enabled by defining WB_RETIRE_CNT_EN.
`ifndef WB_Y86_DEFINES
`define WB_Y86_DEFINES
`define ICODE_BUS     3:0
`define STAT_BUS      2:0
`define DATA_BUS      63:0
`define REG_ADDR_BUS  3:0
`define NREG          4'hF
`define INOP          4'h1
`define SAOK          3'd1
`define SHLT          3'd2
`define SADR          3'd3
`define SINS          3'd4
`endif

package writeback_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_ERR_ADR = 2'd2,
    ST_ERR_INS = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [`ICODE_BUS]    icode;
    logic [`STAT_BUS]     stat;
    logic [`DATA_BUS]     val_e;
    logic [`DATA_BUS]     val_m;
    logic [`REG_ADDR_BUS] dst_e;
    logic [`REG_ADDR_BUS] dst_m;
  } w_entry_t;

  function automatic w_entry_t bubble_entry();
    w_entry_t e;
    e.valid = 1'b0;
    e.icode = `INOP;
    e.stat  = `SAOK;
    e.val_e = '0;
    e.val_m = '0;
    e.dst_e = `NREG;
    e.dst_m = `NREG;
    return e;
  endfunction

endpackage

// File: rtl/wb_stat_fsm.sv
// Processor status FSM: leaves RUN on the edge that loads a faulting W entry and
// then stays in the fault/halt state until reset.
import writeback_pkg::*;

module wb_stat_fsm (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en,
  input  logic [`STAT_BUS] load_stat,
  output logic             run,
  output logic [`STAT_BUS] stat_o,
  output logic             halted_o
);

  wb_state_e state_reg;
  wb_state_e state_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RUN && load_en) begin
      case (load_stat)
        `SHLT:   state_next = ST_HALTED;
        `SADR:   state_next = ST_ERR_ADR;
        `SINS:   state_next = ST_ERR_INS;
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    run      = (state_reg == ST_RUN);
    halted_o = (state_reg != ST_RUN);
    case (state_reg)
      ST_HALTED:  stat_o = `SHLT;
      ST_ERR_ADR: stat_o = `SADR;
      ST_ERR_INS: stat_o = `SINS;
      default:    stat_o = `SAOK;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Y86 writeback stage: W pipeline register, register-file write enables and retire pulse.
// Defining WB_RETIRE_CNT_EN adds a 64-bit wrapping retire counter output.
import writeback_pkg::*;

module writeback (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [`ICODE_BUS]    m_icode_i,
  input  logic [`STAT_BUS]     m_stat_i,
  input  logic [`DATA_BUS]     m_valE_i,
  input  logic [`DATA_BUS]     m_valM_i,
  input  logic [`REG_ADDR_BUS] m_dstE_i,
  input  logic [`REG_ADDR_BUS] m_dstM_i,
  input  logic                 w_stall_i,
  input  logic                 w_bubble_i,
  output logic [`REG_ADDR_BUS] w_dstE_o,
  output logic [`DATA_BUS]     w_valE_o,
  output logic                 w_weE_o,
  output logic [`REG_ADDR_BUS] w_dstM_o,
  output logic [`DATA_BUS]     w_valM_o,
  output logic                 w_weM_o,
  output logic [`STAT_BUS]     stat_o,
  output logic                 halted_o,
  output logic                 retired_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [`DATA_BUS]     retire_cnt_o
`endif
);

  w_entry_t         w_reg;
  w_entry_t         w_next;
  logic             retired_reg;
  logic             retired_next;
  logic             run;
  logic             load_en;
  logic [`STAT_BUS] load_stat;
  logic             we_ok;
  logic             unused_icode;

  // Once the FSM leaves RUN nothing loads, so the faulting entry stays frozen in W.
  assign load_en   = run && !w_stall_i;
  assign load_stat = w_bubble_i ? `SAOK : m_stat_i;

  wb_stat_fsm u_stat_fsm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_en   (load_en),
    .load_stat (load_stat),
    .run       (run),
    .stat_o    (stat_o),
    .halted_o  (halted_o)
  );

  always_comb begin
    w_next = w_reg;
    if (w_bubble_i) begin
      w_next = bubble_entry();
    end else begin
      w_next.valid = 1'b1;
      w_next.icode = m_icode_i;
      w_next.stat  = m_stat_i;
      w_next.val_e = m_valE_i;
      w_next.val_m = m_valM_i;
      w_next.dst_e = m_dstE_i;
      w_next.dst_m = m_dstM_i;
    end
  end

  assign retired_next = load_en && !w_bubble_i && (m_stat_i == `SAOK);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_reg       <= bubble_entry();
      retired_reg <= 1'b0;
    end else begin
      if (load_en) begin
        w_reg <= w_next;
      end
      retired_reg <= retired_next;
    end
  end

  assign w_dstE_o  = w_reg.dst_e;
  assign w_valE_o  = w_reg.val_e;
  assign w_dstM_o  = w_reg.dst_m;
  assign w_valM_o  = w_reg.val_m;
  assign retired_o = retired_reg;

  // Same destination on both ports (popq %rsp): the memory value wins.
  assign we_ok   = w_reg.valid && (w_reg.stat == `SAOK) && run;
  assign w_weM_o = we_ok && (w_reg.dst_m != `NREG);
  assign w_weE_o = we_ok && (w_reg.dst_e != `NREG) && (w_reg.dst_e != w_reg.dst_m);

  assign unused_icode = ^w_reg.icode;

`ifdef WB_RETIRE_CNT_EN
  logic [`DATA_BUS] retire_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retire_cnt_reg <= '0;
    end else if (retired_next) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end
  end

  assign retire_cnt_o = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage.
module tb_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  m_icode_i;
  logic [2:0]  m_stat_i;
  logic [63:0] m_valE_i;
  logic [63:0] m_valM_i;
  logic [3:0]  m_dstE_i;
  logic [3:0]  m_dstM_i;
  logic        w_stall_i;
  logic        w_bubble_i;
  logic [3:0]  w_dstE_o;
  logic [63:0] w_valE_o;
  logic        w_weE_o;
  logic [3:0]  w_dstM_o;
  logic [63:0] w_valM_o;
  logic        w_weM_o;
  logic [2:0]  stat_o;
  logic        halted_o;
  logic        retired_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  writeback dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_icode_i  (m_icode_i),
    .m_stat_i   (m_stat_i),
    .m_valE_i   (m_valE_i),
    .m_valM_i   (m_valM_i),
    .m_dstE_i   (m_dstE_i),
    .m_dstM_i   (m_dstM_i),
    .w_stall_i  (w_stall_i),
    .w_bubble_i (w_bubble_i),
    .w_dstE_o   (w_dstE_o),
    .w_valE_o   (w_valE_o),
    .w_weE_o    (w_weE_o),
    .w_dstM_o   (w_dstM_o),
    .w_valM_o   (w_valM_o),
    .w_weM_o    (w_weM_o),
    .stat_o     (stat_o),
    .halted_o   (halted_o),
    .retired_o  (retired_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o (retire_cnt_o)
`endif
  );

  task automatic set_in(input logic [3:0] ic, input logic [2:0] st, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_icode_i  = ic;
    m_stat_i   = st;
    m_valE_i   = ve;
    m_valM_i   = vm;
    m_dstE_i   = de;
    m_dstM_i   = dm;
    w_stall_i  = 1'b0;
    w_bubble_i = 1'b0;
    $display("txn icode=%h stat=%0d valE=%h valM=%h dstE=%h dstM=%h", ic, st, ve, vm, de, dm);
  endtask

  task automatic set_bubble();
    w_stall_i  = 1'b0;
    w_bubble_i = 1'b1;
    $display("txn bubble");
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #2;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_bubble();
    #12;
    total++; if (w_weE_o !== 1'b0 || w_weM_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b%b want=00", w_weE_o, w_weM_o); end
    total++; if (w_dstE_o !== 4'hF || w_dstM_o !== 4'hF) begin bad++; $display("FAIL reset_dst got=%h/%h want=f/f", w_dstE_o, w_dstM_o); end
    total++; if (w_valE_o !== 64'd0 || w_valM_o !== 64'd0) begin bad++; $display("FAIL reset_val got=%h/%h want=0/0", w_valE_o, w_valM_o); end
    total++; if (stat_o !== 3'd1 || halted_o !== 1'b0 || retired_o !== 1'b0) begin bad++; $display("FAIL reset_stat got=%0d/%b/%b want=1/0/0", stat_o, halted_o, retired_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_irmovq();
    set_in(4'h3, 3'd1, 64'h2A, 64'h0, 4'h2, 4'hF);
    tick();
    total++; if (w_weE_o !== 1'b1 || w_dstE_o !== 4'h2 || w_valE_o !== 64'h2A) begin bad++; $display("FAIL irmovq_e got=%b/%h/%h want=1/2/2a", w_weE_o, w_dstE_o, w_valE_o); end
    total++; if (w_weM_o !== 1'b0 || retired_o !== 1'b1) begin bad++; $display("FAIL irmovq_m_ret got=%b/%b want=0/1", w_weM_o, retired_o); end
    set_bubble();
    tick();
    total++; if (w_weE_o !== 1'b0 || w_dstE_o !== 4'hF || retired_o !== 1'b0) begin bad++; $display("FAIL bubble got=%b/%h/%b want=0/f/0", w_weE_o, w_dstE_o, retired_o); end
  endtask

  task automatic test_popq();
    set_in(4'hB, 3'd1, 64'h48, 64'h99, 4'h4, 4'h4);
    tick();
    total++; if (w_weE_o !== 1'b0 || w_weM_o !== 1'b1) begin bad++; $display("FAIL popq_we got=%b%b want=01", w_weE_o, w_weM_o); end
    total++; if (w_valM_o !== 64'h99 || w_dstM_o !== 4'h4) begin bad++; $display("FAIL popq_m got=%h/%h want=99/4", w_valM_o, w_dstM_o); end
    set_in(4'hB, 3'd1, 64'h50, 64'hAB, 4'h4, 4'h6);
    tick();
    total++; if (w_weE_o !== 1'b1 || w_weM_o !== 1'b1 || w_valE_o !== 64'h50 || w_valM_o !== 64'hAB) begin bad++; $display("FAIL popq_both got=%b%b/%h/%h want=11/50/ab", w_weE_o, w_weM_o, w_valE_o, w_valM_o); end
    set_bubble();
    tick();
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    set_in(4'h3, 3'd1, 64'h11, 64'h0, 4'h7, 4'hF);
    tick();
    if (retired_o === 1'b1) pulses++;
    m_valE_i  = 64'h77;
    m_dstE_i  = 4'h1;
    w_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (retired_o === 1'b1) pulses++;
      total++; if (w_valE_o !== 64'h11 || w_dstE_o !== 4'h7 || w_weE_o !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%b want=11/7/1", i, w_valE_o, w_dstE_o, w_weE_o); end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stall_retire got=%0d want=1", pulses); end
    w_bubble_i = 1'b1;
    tick();
    total++; if (w_valE_o !== 64'h11 || w_weE_o !== 1'b1 || retired_o !== 1'b0) begin bad++; $display("FAIL stall_wins got=%h/%b/%b want=11/1/0", w_valE_o, w_weE_o, retired_o); end
    w_stall_i = 1'b0;
    tick();
    total++; if (w_dstE_o !== 4'hF || w_weE_o !== 1'b0 || retired_o !== 1'b0) begin bad++; $display("FAIL unstall_bubble got=%h/%b/%b want=f/0/0", w_dstE_o, w_weE_o, retired_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      set_in(4'h3, 3'd1, 64'(i * 16), 64'h0, 4'(i), 4'hF);
      tick();
      total++; if (retired_o !== 1'b1 || w_valE_o !== 64'(i * 16) || w_dstE_o !== 4'(i)) begin bad++; $display("FAIL b2b%0d got=%b/%h/%h want=1/%h/%h", i, retired_o, w_valE_o, w_dstE_o, 64'(i * 16), 4'(i)); end
    end
    set_bubble();
    tick();
  endtask

  task automatic test_adr_halt();
    set_in(4'h5, 3'd3, 64'h30, 64'h55, 4'hF, 4'h3);
    tick();
    total++; if (w_weM_o !== 1'b0 || stat_o !== 3'd3 || halted_o !== 1'b1 || retired_o !== 1'b0) begin bad++; $display("FAIL adr got=%b/%0d/%b/%b want=0/3/1/0", w_weM_o, stat_o, halted_o, retired_o); end
    set_in(4'h3, 3'd1, 64'h99, 64'h0, 4'h2, 4'hF);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (w_valE_o !== 64'h30 || w_weE_o !== 1'b0 || stat_o !== 3'd3 || retired_o !== 1'b0) begin bad++; $display("FAIL adr_sticky%0d got=%h/%b/%0d/%b want=30/0/3/0", i, w_valE_o, w_weE_o, stat_o, retired_o); end
    end
  endtask

  task automatic test_reset_mid();
    #3;
    rst_i = 1'b0;
    #1;
    total++; if (stat_o !== 3'd1 || halted_o !== 1'b0 || w_weE_o !== 1'b0 || w_weM_o !== 1'b0 || w_dstM_o !== 4'hF) begin bad++; $display("FAIL reset_mid got=%0d/%b/%b%b/%h want=1/0/00/f", stat_o, halted_o, w_weE_o, w_weM_o, w_dstM_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    set_in(4'h3, 3'd1, 64'h66, 64'h0, 4'h9, 4'hF);
    tick();
    total++; if (retired_o !== 1'b1 || w_weE_o !== 1'b1 || w_valE_o !== 64'h66) begin bad++; $display("FAIL post_reset got=%b/%b/%h want=1/1/66", retired_o, w_weE_o, w_valE_o); end
  endtask

  task automatic test_halt_ins();
    set_in(4'h0, 3'd2, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    total++; if (stat_o !== 3'd2 || halted_o !== 1'b1 || retired_o !== 1'b0) begin bad++; $display("FAIL hlt got=%0d/%b/%b want=2/1/0", stat_o, halted_o, retired_o); end
    do_reset();
    set_in(4'hE, 3'd4, 64'h12, 64'h0, 4'h1, 4'hF);
    tick();
    total++; if (stat_o !== 3'd4 || halted_o !== 1'b1 || w_weE_o !== 1'b0) begin bad++; $display("FAIL ins got=%0d/%b/%b want=4/1/0", stat_o, halted_o, w_weE_o); end
    do_reset();
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_counter();
    set_bubble();
    do_reset();
    total++; if (retire_cnt_o !== 64'd0) begin bad++; $display("FAIL cnt_reset got=%h want=0", retire_cnt_o); end
    set_in(4'h3, 3'd1, 64'h1, 64'h0, 4'h1, 4'hF);
    tick();
    total++; if (retire_cnt_o !== 64'd1) begin bad++; $display("FAIL cnt_inc got=%h want=1", retire_cnt_o); end
    set_bubble();
    tick();
    force dut.retire_cnt_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_reg;
    set_in(4'h3, 3'd1, 64'h2, 64'h0, 4'h1, 4'hF);
    tick();
    total++; if (retire_cnt_o !== 64'd0) begin bad++; $display("FAIL cnt_wrap got=%h want=0", retire_cnt_o); end
    set_bubble();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_irmovq();
    test_popq();
    test_stall();
    test_back_to_back();
    test_adr_halt();
    test_reset_mid();
    set_bubble();
    tick();
    test_halt_ins();
`ifdef WB_RETIRE_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
